// File: rtl/pim_scheduler.sv
// Tile-job scheduler for one full matrix multiply: walks the k-major job list and
// hands each job to a free PIM unit, holding back jobs whose output tile is still in flight.
module pim_scheduler #(
    parameter int NUM_UNITS = 4,
    parameter int TILES     = 2,
    parameter int TW        = (TILES > 1) ? $clog2(TILES) : 1,
    parameter int NJOBS     = TILES * TILES * TILES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_UNITS-1:0] dispatch_valid,
    input  logic [NUM_UNITS-1:0] dispatch_ready,
    output logic [TW-1:0]        job_row,
    output logic [TW-1:0]        job_col,
    output logic [TW-1:0]        job_k,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic                 protocol_err,
    output logic [1:0]           dbg_state
);
    localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int JW = $clog2(NJOBS + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_DRAIN    = 2'd2,
        S_DONE     = 2'd3
    } state_e;

    state_e                           state_q, state_d;
    logic [JW-1:0]                    job_cnt_q, job_cnt_d;
    logic [UW-1:0]                    rr_ptr_q, rr_ptr_d;
    logic [NUM_UNITS-1:0]             valid_q, valid_d;
    logic [TW-1:0]                    row_q, row_d, col_q, col_d, k_q, k_d;
    logic [NUM_UNITS-1:0]             u_busy_q, u_busy_d;
    logic [NUM_UNITS-1:0][2*TW-1:0]   u_tile_q, u_tile_d;
    logic                             err_q, err_d;

    logic [TW-1:0] head_row, head_col, head_k;
    logic          hazard, found, accept;
    logic [UW-1:0] sel, idx, off_idx;

    // Decode the head job and pick a target unit from registered state only.
    always_comb begin
        head_k   = TW'(job_cnt_q / JW'(TILES * TILES));
        head_row = TW'((job_cnt_q / JW'(TILES)) % JW'(TILES));
        head_col = TW'(job_cnt_q % JW'(TILES));
        hazard   = 1'b0;
        found    = 1'b0;
        sel      = '0;
        idx      = '0;
        off_idx  = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (u_busy_q[u] && (u_tile_q[u] == {head_row, head_col})) hazard = 1'b1;
            if (valid_q[u]) off_idx = UW'(u);
        end
        for (int i = 0; i < NUM_UNITS; i++) begin
            idx = UW'((int'(rr_ptr_q) + i) % NUM_UNITS);
            if (!found && !u_busy_q[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        accept = |(valid_q & dispatch_ready);
    end

    always_comb begin
        state_d   = state_q;
        job_cnt_d = job_cnt_q;
        rr_ptr_d  = rr_ptr_q;
        valid_d   = valid_q;
        row_d     = row_q;
        col_d     = col_q;
        k_d       = k_q;
        u_tile_d  = u_tile_q;
        err_d     = err_q | (|(unit_done & ~u_busy_q));
        u_busy_d  = u_busy_q & ~unit_done;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_DISPATCH;
                    job_cnt_d = '0;
                    rr_ptr_d  = '0;
                end
            end
            S_DISPATCH: begin
                if (valid_q == '0) begin
                    if (!hazard && found) begin
                        valid_d = NUM_UNITS'(1) << sel;
                        row_d   = head_row;
                        col_d   = head_col;
                        k_d     = head_k;
                    end
                end else if (accept) begin
                    u_busy_d[off_idx] = 1'b1;
                    u_tile_d[off_idx] = {row_q, col_q};
                    job_cnt_d         = job_cnt_q + JW'(1);
                    rr_ptr_d          = (int'(off_idx) == NUM_UNITS - 1) ? '0 : off_idx + UW'(1);
                    valid_d           = '0;
                    if (job_cnt_q == JW'(NJOBS - 1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (u_busy_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            job_cnt_q <= '0;
            rr_ptr_q  <= '0;
            valid_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
            k_q       <= '0;
            u_busy_q  <= '0;
            u_tile_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            job_cnt_q <= job_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            valid_q   <= valid_d;
            row_q     <= row_d;
            col_q     <= col_d;
            k_q       <= k_d;
            u_busy_q  <= u_busy_d;
            u_tile_q  <= u_tile_d;
            err_q     <= err_d;
        end
    end

    assign busy           = (state_q == S_DISPATCH) || (state_q == S_DRAIN);
    assign done           = (state_q == S_DONE);
    assign dispatch_valid = valid_q;
    assign job_row        = row_q;
    assign job_col        = col_q;
    assign job_k          = k_q;
    assign protocol_err   = err_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_pim_scheduler.sv
// Directed bench for pim_scheduler: per-unit latency model, accept log and
// hand-computed job/unit table, cycle-exact checks on the hazard and drain timing.
module tb_pim_scheduler;
    logic       clk = 1'b0;
    logic       rst_n, start;
    logic       busy, done, protocol_err;
    logic [3:0] dispatch_valid, dispatch_ready, unit_done;
    logic [0:0] job_row, job_col, job_k;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    pim_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .job_row(job_row), .job_col(job_col), .job_k(job_k),
        .unit_done(unit_done), .protocol_err(protocol_err), .dbg_state(dbg_state)
    );

    // {unit, row, col, k} expected for jobs 0..7
    localparam logic [4:0] EXP_TAB [8] = '{5'b00_000, 5'b01_010, 5'b10_100, 5'b11_110,
                                           5'b00_001, 5'b01_011, 5'b10_101, 5'b11_111};

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int done_base = 0;
    int acc_base = 0;
    int start_cyc = 0;
    int lat [4];
    int cnt [4];
    logic [3:0] inj;
    logic [4:0] acc_log [$];
    logic [4:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #1;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Unit model: logs accepts and pulses unit_done lat[u] cycles after the accept edge.
    always @(negedge clk) begin
        for (int u = 0; u < 4; u++) begin
            if (!rst_n) begin
                cnt[u] = 0;
                unit_done[u] = 1'b0;
            end else begin
                unit_done[u] = inj[u];
                if (cnt[u] > 0) begin
                    cnt[u]--;
                    if (cnt[u] == 0) unit_done[u] = 1'b1;
                end
                if (dispatch_valid[u] && dispatch_ready[u]) begin
                    cnt[u] = lat[u];
                    acc_log.push_back({2'(u), job_row, job_col, job_k});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_exp(input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(EXP_TAB[i]);
        acc_base  = acc_log.size();
        done_base = done_cnt;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_acc(input int n, input int budget);
        int k = 0;
        while ((acc_log.size() - acc_base) < n && k < budget) begin
            tick();
            k++;
        end
        check("wait_acc", 32'((acc_log.size() - acc_base) >= n), 1);
    endtask

    task automatic check_log();
        int n = exp_q.size();
        check("acc_count", acc_log.size() - acc_base, n);
        for (int i = 0; i < n; i++)
            if (acc_base + i < acc_log.size())
                check($sformatf("acc%0d", i), acc_log[acc_base + i], exp_q[i]);
    endtask

    task automatic finish_run(input int budget);
        int k = 0;
        while (done_cnt == done_base && k < budget) begin
            tick();
            k++;
        end
        check("done_seen", 32'(done_cnt > done_base), 1);
        repeat (3) tick();
        check("done_once", done_cnt - done_base, 1);
        check("busy_after", busy, 0);
        check_log();
    endtask

    task automatic check_idle(input string pfx);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_valid"}, dispatch_valid, 0);
        check({pfx, "_fields"}, {job_row, job_col, job_k}, 0);
        check({pfx, "_perr"}, protocol_err, 0);
        check({pfx, "_state"}, dbg_state, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        dispatch_ready = 4'hf;
        inj = 4'h0;
        lat = '{3, 3, 3, 3};
        repeat (2) tick();
        check_idle("rst");
        rst_n = 1'b1;
        tick();

        // Nominal run
        load_exp(8);
        start_run();
        check("e0_busy", busy, 1);
        check("e0_valid", dispatch_valid, 0);
        tick();
        check("e1_valid", dispatch_valid, 4'b0001);
        check("e1_fields", {job_row, job_col, job_k}, 3'b000);
        finish_run(60);
        check("nom_done_latency", done_cyc - start_cyc, 20);
        check("nom_perr", protocol_err, 0);

        // Tile hazard: unit 0 holds tile 00 for 20 cycles
        lat = '{20, 1, 1, 1};
        load_exp(8);
        start_run();
        wait_acc(4, 30);
        begin
            int k = 0;
            while (dispatch_valid == 4'b0000 && k < 40) begin
                tick();
                k++;
            end
        end
        check("hz_offer_cycle", cyc - start_cyc, 23);
        check("hz_offer_valid", dispatch_valid, 4'b0001);
        check("hz_offer_fields", {job_row, job_col, job_k}, 3'b001);
        lat = '{3, 3, 3, 3};
        finish_run(100);

        // Backpressure on unit 2 during job 2
        dispatch_ready = 4'b1011;
        load_exp(8);
        start_run();
        begin
            int k = 0;
            while (dispatch_valid != 4'b0100 && k < 20) begin
                tick();
                k++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_hold%0d", i), {dispatch_valid, job_row, job_col, job_k}, 7'b0100_100);
            tick();
        end
        dispatch_ready = 4'b1111;
        tick();
        check("bp_valid_clear", dispatch_valid, 0);
        check("bp_acc_n", acc_log.size() - acc_base, 3);
        finish_run(60);

        // Stray unit_done and a start while busy
        load_exp(8);
        start_run();
        tick();
        inj = 4'b1000;
        tick();
        inj = 4'b0000;
        tick();
        check("perr_set", protocol_err, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_run(60);
        check("perr_sticky", protocol_err, 1);

        // Reset right after job 5 is accepted
        load_exp(6);
        start_run();
        wait_acc(6, 40);
        rst_n = 1'b0;
        tick();
        check_idle("midrst");
        rst_n = 1'b1;
        tick();
        check_log();
        load_exp(8);
        start_run();
        tick();
        check("rs_valid", dispatch_valid, 4'b0001);
        check("rs_fields", {job_row, job_col, job_k}, 3'b000);
        finish_run(60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
